// File: rtl/shift_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// shift_arbiter_ctrl
//
// Lets two requesters share one registered shifter. Only one operation is in
// flight at a time. When both requesters are valid, the one that was not
// served last is granted.
//
// The controller drives the winner's operands to the shifter and waits out
// the shifter latency. It then captures the shifter output and returns it,
// tagged with the owner's ID, on a valid/ready response channel.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   reqN_valid/ready      request handshake (N = 0, 1); ready is combinational
//   reqN_a/fill/ctrl      operand, fill pattern and control code
//   sh_a/sh_fill/sh_ctrl  registered operands driven to the shifter
//   sh_out                shifter result (valid LAT cycles after ISSUE)
//   rsp_valid/ready       response handshake
//   rsp_id/rsp_data       owner of the result and the captured result
//   busy                  high in every state except IDLE
//
// Flow: IDLE -> ISSUE (1 cycle) -> WAIT (LAT cycles) -> RESP -> IDLE
// -----------------------------------------------------------------------------
module shift_arbiter_ctrl #(
  parameter int              W         = 16,
  parameter int              CW        = 4,
  parameter int              LAT       = 1,
  parameter logic [CW-1:0]   IDLE_CTRL = 4'h0
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_fill,
  input  logic [CW-1:0] req0_ctrl,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_fill,
  input  logic [CW-1:0] req1_ctrl,

  output logic [W-1:0]  sh_a,
  output logic [W-1:0]  sh_fill,
  output logic [CW-1:0] sh_ctrl,
  input  logic [W-1:0]  sh_out,

  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [W-1:0]  rsp_data,
  output logic          busy
);

  // The wait counter must hold LAT-1; keep it at least one bit wide so that
  // LAT = 1 still gives a legal vector.
  localparam int              CNTW     = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LAT - 1);
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CNTW-1:0] cnt_r;
  logic            last_r;      // ID of the requester served most recently
  logic            gnt_valid_s; // some requester is eligible this cycle
  logic            gnt_id_s;    // ID of the eligible requester
  logic            accept_s;    // request handshake happens at this edge

  // Round-robin grant. On contention the requester not served last wins.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = ~last_r;
    end else if (req0_valid) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = 1'b0;
    end else if (req1_valid) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = 1'b1;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
    end
  end

  // Ready only in IDLE, and only toward the granted requester.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if ((state_r == ST_IDLE) && gnt_valid_s) begin
      req0_ready = ~gnt_id_s;
      req1_ready = gnt_id_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  assign accept_s = req0_ready | req1_ready;

  // Next-state logic for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        // The response handshake returns to IDLE. A new request can be
        // accepted on the following cycle at the earliest.
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and all registered outputs and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      last_r    <= 1'b1;
      sh_a      <= {W{1'b0}};
      sh_fill   <= {W{1'b0}};
      sh_ctrl   <= IDLE_CTRL;
      rsp_data  <= {W{1'b0}};
      rsp_id    <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      busy      <= (state_nxt_s != ST_IDLE);
      rsp_valid <= (state_nxt_s == ST_RESP);
      case (state_r)
        ST_IDLE: begin
          // Only the values present at the handshake edge are used.
          if (accept_s) begin
            sh_a    <= gnt_id_s ? req1_a    : req0_a;
            sh_fill <= gnt_id_s ? req1_fill : req0_fill;
            sh_ctrl <= gnt_id_s ? req1_ctrl : req0_ctrl;
            rsp_id  <= gnt_id_s;
            last_r  <= gnt_id_s;
          end
        end
        ST_ISSUE: begin
          cnt_r <= CNT_LOAD;
        end
        ST_WAIT: begin
          // Sample sh_out only in the final WAIT cycle. Earlier shifter
          // output is never seen. sh_a and sh_fill keep their values
          // through RESP.
          if (cnt_r == CNT_ZERO) begin
            rsp_data <= sh_out;
            sh_ctrl  <= IDLE_CTRL;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_RESP: begin
          // Hold the result and ID until the consumer accepts them.
          rsp_data <= rsp_data;
        end
        default: begin
          sh_ctrl <= IDLE_CTRL;
        end
      endcase
    end
  end

endmodule
